shift_op_sequencer: RTL and testbench
=====================================

// Module: shift_op_sequencer
// PURPOSE
//  Command-driven controller for the N-bit logic-processor datapath (register unit A/B + compute/routing unit).
//  Accepts LOAD_A / LOAD_B / EXECUTE commands over a valid/ready handshake.
//  Generates Ld_A, Ld_B and a Shift_En burst of programmable length, and holds the latched F/R select.
//  Sits between the switch/host front end and the register/compute datapath.
// PARAMETERS
//  WIDTH    8  datapath width in bits; default shift-burst length
//  CNT_W    $clog2(WIDTH+1)  width of Cmd_Count and the internal counter (derived, do not override)
// PORTS
//  Clk        in   1      single clock, all logic on posedge
//  Reset_n    in   1      synchronous, active-low reset
//  Cmd_Valid  in   1      command present
//  Cmd_Ready  out  1      sequencer can accept a command
//  Cmd_Op     in   2      seq_pkg::op_t: 0 NOP, 1 LOAD_A, 2 LOAD_B, 3 EXECUTE
//  Cmd_F      in   3      compute function select, latched on EXECUTE accept
//  Cmd_R      in   2      routing select, latched on EXECUTE accept
//  Cmd_Count  in   CNT_W  shift cycles for EXECUTE; 0 or >WIDTH means WIDTH
//  Ld_A       out  1      load register A (one-cycle pulse)
//  Ld_B       out  1      load register B (one-cycle pulse)
//  Shift_En   out  1      shift both registers this cycle
//  F          out  3      held function select to compute unit
//  R          out  2      held routing select to compute unit
//  Busy       out  1      high in every state except IDLE
//  Done       out  1      one-cycle pulse after the last shift of an EXECUTE
//  Pause      in   1      present only with SEQ_PAUSE_EN; freezes a shift burst
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge, any state, mid-burst included):
//   - state=IDLE, counter=0, F=0, R=0.
//   - All outputs 0, except Cmd_Ready=1 from the first cycle after reset.
//  Handshake: command accepted when Cmd_Valid & Cmd_Ready at posedge.
//   - Cmd_Ready = (state==IDLE).
//   - Cmd_Valid while busy is ignored; the requester must hold it.
//  States (seq_pkg::state_t): IDLE, LOAD, SHIFT, DONE.
//   - IDLE -> LOAD on accepted LOAD_A or LOAD_B (op remembered).
//   - IDLE -> SHIFT on accepted EXECUTE; counter := effective count; F/R latched.
//   - IDLE stays IDLE on accepted NOP (consumed, no side effects).
//   - LOAD: Ld_A or Ld_B high for exactly 1 cycle -> IDLE.
//   - SHIFT: Shift_En=1; counter decrements each cycle; when counter==1 -> DONE.
//   - DONE: Done=1 for 1 cycle -> IDLE.
//  Latency, accept edge t:
//   - LOAD: Ld_x high in cycle t+1; Cmd_Ready high again at t+2.
//   - EXECUTE (count n): Shift_En high exactly n consecutive cycles t+1..t+n.
//     Done at t+n+1; Ready at t+n+2.
//  Ld_A, Ld_B, Shift_En are mutually exclusive at all times.
//  F/R change only on EXECUTE accept and hold through IDLE until the next EXECUTE.
//  Counter never underflows or wraps; effective count is always in 1..WIDTH.
// CONFIGURATION
//  SEQ_PAUSE_EN defined:
//   - Pause port exists.
//   - In SHIFT with Pause=1: Shift_En=0, counter holds, state holds.
//   - Pause has no effect in other states; burst total stays exactly n shift cycles.
//  SEQ_PAUSE_EN undefined: no Pause port; SHIFT bursts are contiguous.
// STRUCTURE
//  seq_pkg:
//   - op_t enum (2 bits).
//   - state_t enum (2 bits).
//   - constants OP_NOP / OP_LOAD_A / OP_LOAD_B / OP_EXECUTE.
//  Sub-module shift_burst_counter:
//   - CNT_W down-counter with load, enable, clear.
//   - last flag asserted when value==1.
//  Top level: FSM (two-process: always_ff state/regs, always_comb next-state/outputs) plus F/R holding registers.
// TESTING
//  1. Reset_n=0 for 2 cycles -> all outputs 0; after release Cmd_Ready=1, Busy=0.
//  2. LOAD_A accepted at t -> Ld_A=1 only at t+1, Ld_B=0, Ready=1 at t+2; repeat for LOAD_B.
//  3. EXECUTE F=3'b101 R=2'b10 Count=0 (WIDTH=8) -> Shift_En high 8 cycles, Done at t+9, F/R held after.
//  4. EXECUTE Count=3 with Cmd_Valid held continuously -> exactly 3 Shift_En cycles, next command accepted at t+5.
//  5. Reset_n=0 mid-SHIFT (after 4 shifts) -> next cycle IDLE, Shift_En=0, no Done pulse.
//  6. SEQ_PAUSE_EN build: Count=4, Pause=1 for 2 cycles after the 2nd shift -> 4 shifts total, Done at t+7.

Source files
------------

// File: rtl/shift_op_sequencer_pkg.sv
// Shared types for the shift-op sequencer: command opcodes and FSM state encoding.
package seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_LOAD_A  = 2'd1,
        OP_LOAD_B  = 2'd2,
        OP_EXECUTE = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_op_sequencer_if.sv
// Command channel (valid/ready plus payload) between the host front end and the sequencer.
interface shift_op_sequencer_if #(
    parameter int WIDTH = 8
);
    import seq_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Cmd_Valid;
    logic             Cmd_Ready;
    op_t              Cmd_Op;
    logic [2:0]       Cmd_F;
    logic [1:0]       Cmd_R;
    logic [CNT_W-1:0] Cmd_Count;

    modport master (
        output Cmd_Valid,
        output Cmd_Op,
        output Cmd_F,
        output Cmd_R,
        output Cmd_Count,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid,
        input  Cmd_Op,
        input  Cmd_F,
        input  Cmd_R,
        input  Cmd_Count,
        output Cmd_Ready
    );

endinterface

// File: rtl/shift_op_sequencer_counter.sv
// Burst down-counter: clear beats load beats decrement; stops at zero, flags value==1.
module shift_burst_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_op_sequencer.sv
// Command-driven sequencer issuing Ld_A/Ld_B pulses and Shift_En bursts, holding F/R.
// Optional burst freeze via Pause when SEQ_PAUSE_EN is defined.
module shift_op_sequencer
    import seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    shift_op_sequencer_if.slave  cmd,
    output logic                 Ld_A,
    output logic                 Ld_B,
    output logic                 Shift_En,
    output logic [2:0]           F,
    output logic [1:0]           R,
    output logic                 Busy,
    output logic                 Done
`ifdef SEQ_PAUSE_EN
    ,
    input  logic                 Pause
`endif
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [2:0]       f_q, f_d;
    logic [1:0]       r_q, r_d;
    logic             cnt_load, cnt_en, cnt_clear, cnt_last;
    logic [CNT_W-1:0] eff_count;
    logic             accept;
    logic             paused;

`ifdef SEQ_PAUSE_EN
    assign paused = Pause;
`else
    assign paused = 1'b0;
`endif

    // Ready is masked while reset is held so no command appears accepted during reset.
    assign cmd.Cmd_Ready = Reset_n && (state_q == IDLE);
    assign accept        = cmd.Cmd_Valid && cmd.Cmd_Ready;

    always_comb begin
        if ((cmd.Cmd_Count == '0) || (cmd.Cmd_Count > CNT_W'(WIDTH))) begin
            eff_count = CNT_W'(WIDTH);
        end else begin
            eff_count = cmd.Cmd_Count;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f_d       = f_q;
        r_d       = r_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
        Ld_A      = 1'b0;
        Ld_B      = 1'b0;
        Shift_En  = 1'b0;
        Done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd.Cmd_Op)
                        OP_LOAD_A, OP_LOAD_B: begin
                            op_d    = cmd.Cmd_Op;
                            state_d = LOAD;
                        end
                        OP_EXECUTE: begin
                            f_d      = cmd.Cmd_F;
                            r_d      = cmd.Cmd_R;
                            cnt_load = 1'b1;
                            state_d  = SHIFT;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                Ld_A    = (op_q == OP_LOAD_A);
                Ld_B    = (op_q == OP_LOAD_B);
                state_d = IDLE;
            end
            SHIFT: begin
                if (!paused) begin
                    Shift_En = 1'b1;
                    cnt_en   = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                Done      = 1'b1;
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            f_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f_q     <= f_d;
            r_q     <= r_d;
        end
    end

    shift_burst_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (eff_count),
        .en_i       (cnt_en),
        .last_o     (cnt_last)
    );

    assign Busy = (state_q != IDLE);
    assign F    = f_q;
    assign R    = r_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed self-checking bench for shift_op_sequencer (WIDTH=8); covers pause when SEQ_PAUSE_EN is defined.
module tb_shift_op_sequencer;
    import seq_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic       Ld_A, Ld_B, Shift_En, Busy, Done;
    logic [2:0] F;
    logic [1:0] R;
`ifdef SEQ_PAUSE_EN
    logic       Pause;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    shift_op_sequencer_if #(.WIDTH(8)) cmd_if ();

    shift_op_sequencer #(.WIDTH(8)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .cmd      (cmd_if),
        .Ld_A     (Ld_A),
        .Ld_B     (Ld_B),
        .Shift_En (Shift_En),
        .F        (F),
        .R        (R),
        .Busy     (Busy),
        .Done     (Done)
`ifdef SEQ_PAUSE_EN
        ,
        .Pause    (Pause)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller is at a negedge with Ready=1; accept edge t is the next posedge, loop index k is cycle t+k.
    task automatic run_exec(input string name, input logic [2:0] f, input logic [1:0] r,
                            input logic [3:0] cnt, input int unsigned n);
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Op    = OP_EXECUTE;
        cmd_if.Cmd_F     = f;
        cmd_if.Cmd_R     = r;
        cmd_if.Cmd_Count = cnt;
        for (int unsigned k = 1; k <= n + 2; k++) begin
            @(negedge Clk);
            check_eq($sformatf("%s_shift_k%0d", name, k), 32'(Shift_En), 32'(k <= n));
            check_eq($sformatf("%s_done_k%0d", name, k), 32'(Done), 32'(k == n + 1));
            check_eq($sformatf("%s_ready_k%0d", name, k), 32'(cmd_if.Cmd_Ready), 32'(k == n + 2));
            check_eq($sformatf("%s_ld_k%0d", name, k), 32'(Ld_A | Ld_B), 32'(0));
            if (k == 1) cmd_if.Cmd_Valid = 1'b0;
        end
        check_eq({name, "_F"}, 32'(F), 32'(f));
        check_eq({name, "_R"}, 32'(R), 32'(r));
    endtask

    task automatic run_load(input string name, input op_t op);
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Op    = op;
        @(negedge Clk);
        check_eq({name, "_lda_t1"}, 32'(Ld_A), 32'(op == OP_LOAD_A));
        check_eq({name, "_ldb_t1"}, 32'(Ld_B), 32'(op == OP_LOAD_B));
        check_eq({name, "_shift_t1"}, 32'(Shift_En), 32'(0));
        check_eq({name, "_busy_t1"}, 32'(Busy), 32'(1));
        check_eq({name, "_ready_t1"}, 32'(cmd_if.Cmd_Ready), 32'(0));
        cmd_if.Cmd_Valid = 1'b0;
        @(negedge Clk);
        check_eq({name, "_ld_t2"}, 32'(Ld_A | Ld_B), 32'(0));
        check_eq({name, "_ready_t2"}, 32'(cmd_if.Cmd_Ready), 32'(1));
        check_eq({name, "_busy_t2"}, 32'(Busy), 32'(0));
    endtask

    initial begin
        Reset_n          = 1'b0;
        cmd_if.Cmd_Valid = 1'b0;
        cmd_if.Cmd_Op    = OP_NOP;
        cmd_if.Cmd_F     = 3'd0;
        cmd_if.Cmd_R     = 2'd0;
        cmd_if.Cmd_Count = 4'd0;
`ifdef SEQ_PAUSE_EN
        Pause            = 1'b0;
`endif

        // Reset held for two cycles
        repeat (2) @(negedge Clk);
        check_eq("rst_lda", 32'(Ld_A), 32'(0));
        check_eq("rst_ldb", 32'(Ld_B), 32'(0));
        check_eq("rst_shift", 32'(Shift_En), 32'(0));
        check_eq("rst_busy", 32'(Busy), 32'(0));
        check_eq("rst_done", 32'(Done), 32'(0));
        check_eq("rst_F", 32'(F), 32'(0));
        check_eq("rst_R", 32'(R), 32'(0));
        check_eq("rst_ready", 32'(cmd_if.Cmd_Ready), 32'(0));
        Reset_n = 1'b1;
        @(negedge Clk);
        check_eq("post_rst_ready", 32'(cmd_if.Cmd_Ready), 32'(1));
        check_eq("post_rst_busy", 32'(Busy), 32'(0));

        run_load("loada", OP_LOAD_A);
        run_load("loadb", OP_LOAD_B);

        // Count 0 maps to WIDTH=8
        run_exec("exec_c0", 3'b101, 2'b10, 4'd0, 8);

        // NOP is consumed without side effects; F/R keep the last EXECUTE values
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Op    = OP_NOP;
        cmd_if.Cmd_F     = 3'b010;
        @(negedge Clk);
        check_eq("nop_busy", 32'(Busy), 32'(0));
        check_eq("nop_ready", 32'(cmd_if.Cmd_Ready), 32'(1));
        check_eq("nop_ld", 32'(Ld_A | Ld_B | Shift_En), 32'(0));
        check_eq("nop_F", 32'(F), 32'(3'b101));
        check_eq("nop_R", 32'(R), 32'(2'b10));
        cmd_if.Cmd_Valid = 1'b0;

        // Boundaries: count above WIDTH saturates to 8, count 1 gives a single shift
        run_exec("exec_c9", 3'b001, 2'b01, 4'd9, 8);
        run_exec("exec_c1", 3'b111, 2'b11, 4'd1, 1);

        // Valid held continuously: burst 1 at k=1..3, Done k=4, accept at end of k=5, burst 2 at k=6..8
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Op    = OP_EXECUTE;
        cmd_if.Cmd_F     = 3'b011;
        cmd_if.Cmd_R     = 2'b01;
        cmd_if.Cmd_Count = 4'd3;
        for (int unsigned k = 1; k <= 10; k++) begin
            @(negedge Clk);
            check_eq($sformatf("hold_shift_k%0d", k), 32'(Shift_En),
                     32'((k >= 1 && k <= 3) || (k >= 6 && k <= 8)));
            check_eq($sformatf("hold_done_k%0d", k), 32'(Done), 32'(k == 4 || k == 9));
            check_eq($sformatf("hold_ready_k%0d", k), 32'(cmd_if.Cmd_Ready), 32'(k == 5 || k == 10));
            if (k == 6) cmd_if.Cmd_Valid = 1'b0;
        end

        // Reset in the middle of a burst, after four shifts
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_F     = 3'b110;
        cmd_if.Cmd_R     = 2'b11;
        cmd_if.Cmd_Count = 4'd0;
        for (int unsigned k = 1; k <= 4; k++) begin
            @(negedge Clk);
            check_eq($sformatf("midrst_shift_k%0d", k), 32'(Shift_En), 32'(1));
            cmd_if.Cmd_Valid = 1'b0;
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        check_eq("midrst_shift", 32'(Shift_En), 32'(0));
        check_eq("midrst_busy", 32'(Busy), 32'(0));
        check_eq("midrst_done", 32'(Done), 32'(0));
        check_eq("midrst_F", 32'(F), 32'(0));
        check_eq("midrst_R", 32'(R), 32'(0));
        Reset_n = 1'b1;
        @(negedge Clk);
        check_eq("midrst_done_after", 32'(Done), 32'(0));
        check_eq("midrst_ready_after", 32'(cmd_if.Cmd_Ready), 32'(1));

`ifdef SEQ_PAUSE_EN
        // Count 4, paused for k=3..4: shifts k=1,2,5,6, Done k=7
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Op    = OP_EXECUTE;
        cmd_if.Cmd_Count = 4'd4;
        for (int unsigned k = 1; k <= 8; k++) begin
            @(negedge Clk);
            check_eq($sformatf("pause_shift_k%0d", k), 32'(Shift_En),
                     32'(k == 1 || k == 2 || k == 5 || k == 6));
            check_eq($sformatf("pause_done_k%0d", k), 32'(Done), 32'(k == 7));
            check_eq($sformatf("pause_busy_k%0d", k), 32'(Busy), 32'(k <= 7));
            cmd_if.Cmd_Valid = 1'b0;
            if (k == 2) Pause = 1'b1;
            if (k == 4) Pause = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
